itof_pipe: RTL and testbench
============================

Name: itof_pipe

Overview:
- Pipelined integer-to-single-precision converter for the FPU.
- Generalised successor of the combinational int-to-float unit:
  - parametrised input width and latency
  - signed or unsigned source, selected per operation
  - round-to-nearest-even or round-toward-zero, instead of truncation only
- Accepts one operation per cycle through the FPU's order/accepted/done handshake.
- Result leaves a fixed LATENCY cycles after acceptance.

Parameters:
- WIDTH, 32, integer operand width; legal range 8..32.
- LATENCY, 3, cycles from accepted to done; legal values 1, 2, 3.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous, active-low reset.
- order  input  1  operation request; operands valid while high.
- accepted  output  1  operation taken this cycle.
- done  output  1  rd valid this cycle; one-cycle pulse per operation.
- rs1  input  WIDTH  integer operand.
- is_unsigned  input  1  1 = rs1 unsigned, 0 = two's complement.
- rm  input  1  rounding mode: 0 = round-to-nearest-even, 1 = round-toward-zero.
- rd  output  32  IEEE-754 single result.

Behaviour:
- Reset state: clk and rstn only as listed above; reset is asynchronous and active-low.
  - While rstn low: all valid bits, done, rd (32'h0) and any flags cleared immediately.
  - Operations in flight at reset are discarded; no done is produced for them.
- Handshake:
  - accepted = order, combinationally; there is no backpressure.
  - rs1, is_unsigned and rm are sampled at the clk edge where order is high.
  - done rises exactly LATENCY cycles after that edge.
  - Back-to-back orders give back-to-back done pulses, in order.
  - rd holds its last value while done is low.
- Pipeline, valid bit per stage (LATENCY=3):
  - S1 registers sign, magnitude, rm.
  - S2 registers leading-zero count and normalised magnitude.
  - S3 registers the rounded, packed result.
  - LATENCY=2 merges S1 into S2; LATENCY=1 keeps only the S3 register.
- Sign and magnitude:
  - sign = rs1[WIDTH-1] & ~is_unsigned.
  - mag = sign ? -rs1 : rs1, computed in WIDTH bits, unsigned.
  - The most-negative signed value gives mag = 2^(WIDTH-1), correct as unsigned.
- Normalise:
  - p = index of the leading one of mag.
  - exponent = 127 + p.
  - Mantissa = the 23 bits below the leading one.
  - guard = next bit down; sticky = OR of all remaining lower bits. Zero-fill when p < 24.
- Round:
  - RNE increments the mantissa when guard & (sticky | mantissa[0]).
  - RTZ never increments.
  - Mantissa carry-out sets the mantissa to 0 and adds 1 to the exponent.
  - Exponent never exceeds 127+WIDTH, so there is no overflow or infinity.
- Zero: mag = 0 gives rd = 32'h00000000 (+0), for both signed and unsigned.
- Results are sign-magnitude; negative zero is never produced.

Optional Feature:
- Macro: ITOF_PIPE_INEXACT_EN.
- When defined:
  - Adds output port nx (1 bit), valid with done.
  - nx = guard | sticky of the converted value, in either rounding mode.
  - nx reset value 0; held with rd.
- When undefined:
  - Port absent; guard/sticky still drive rounding.
  - No extra registers.

Test Plan:
- Basic, WIDTH=32, LATENCY=3, RNE, signed:
  - rs1=1 -> rd=32'h3F800000, done exactly 3 cycles after accepted.
  - rs1=0 -> 32'h00000000.
  - rs1=-1 -> 32'hBF800000.
- Rounding:
  - rs1=32'h7FFFFFFF, RNE -> 32'h4F000000 (carry into exponent); RTZ -> 32'h4EFFFFFF.
  - rs1=16777217, RNE -> 32'h4B800000 (tie to even).
  - rs1=16777219, RNE -> 32'h4B800002.
- Extremes and unsigned:
  - rs1=32'h80000000 signed -> 32'hCF000000.
  - Same operand, is_unsigned=1 -> 32'h4F000000.
  - rs1=32'hFFFFFFFF unsigned, RNE -> 32'h4F800000; RTZ -> 32'h4F7FFFFF.
- Throughput: order held high for 5 cycles with rs1=1..5 -> 5 consecutive done pulses:
  - 3F800000
  - 40000000
  - 40400000
  - 40800000
  - 40A00000
- Reset mid-flight: assert rstn low one cycle after two orders -> done never pulses for them, rd=0. The first order after release completes normally.
- Parameters: WIDTH=16, LATENCY=1, signed rs1=16'h8000 -> rd=32'hC7000000 one cycle after accepted. With ITOF_PIPE_INEXACT_EN, rs1=16777217 -> nx=1; rs1=2 -> nx=0.

Source files
------------

// File: rtl/itof_pipe.sv
// itof_pipe: pipelined integer to IEEE-754 single-precision converter.
//
// Converts a WIDTH-bit signed or unsigned integer into a binary32 value,
// rounding either to nearest-even or toward zero. There is no backpressure,
// so one operation can be issued every cycle. The result appears a fixed
// LATENCY cycles after the cycle in which the operation was accepted.
//
// Parameters:
//   WIDTH    integer operand width, 8..32
//   LATENCY  accepted-to-done distance in cycles, 1..3
//
// Ports:
//   clk          clock, rising edge
//   rstn         asynchronous active-low reset; discards operations in flight
//   order        operation request, operands valid while high
//   accepted     operation taken this cycle (equal to order)
//   done         rd valid this cycle, one pulse per operation
//   rs1          integer operand
//   is_unsigned  1 = rs1 unsigned, 0 = two's complement
//   rm           0 = round-to-nearest-even, 1 = round-toward-zero
//   rd           binary32 result, held while done is low
//   nx           inexact flag, valid with done (only with ITOF_PIPE_INEXACT_EN)
//
// Optional feature: define ITOF_PIPE_INEXACT_EN to add the nx output.
//
// Pipeline: S1 holds sign/magnitude/rm, S2 holds leading-zero count and the
// normalised magnitude, S3 holds the rounded, packed result. A LATENCY of 2
// turns S1 into wires and a LATENCY of 1 also turns S2 into wires.
module itof_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             order,
    output logic             accepted,
    output logic             done,
    input  logic [WIDTH-1:0] rs1,
    input  logic             is_unsigned,
    input  logic             rm,
    output logic [31:0]      rd
`ifdef ITOF_PIPE_INEXACT_EN
    ,
    output logic             nx
`endif
);

    // Left shift that moves bit WIDTH-1 of the normalised magnitude to bit 31.
    localparam int          ALIGN   = 32 - WIDTH;
    // Biased exponent of a value whose leading one sits at bit WIDTH-1.
    localparam logic [7:0]  EXP_TOP = 8'(126 + WIDTH);

    // Number of zeros above the leading one; WIDTH for a zero operand.
    function automatic logic [5:0] count_lz(input logic [WIDTH-1:0] v);
        logic [5:0] n;
        logic       hit;
        n   = 6'd0;
        hit = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                hit = 1'b1;
            end else if (!hit) begin
                n = n + 6'd1;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    logic             sign_s;
    logic [WIDTH-1:0] mag_s;

    logic             s1_valid;
    logic             s1_sign;
    logic [WIDTH-1:0] s1_mag;
    logic             s1_rm;

    logic [5:0]       lzc_s;
    logic [WIDTH-1:0] shifted_s;
    logic [31:0]      norm_s;

    logic             s2_valid;
    logic             s2_sign;
    logic             s2_rm;
    logic [5:0]       s2_lzc;
    logic [31:0]      s2_norm;

    logic [7:0]       exp_base_s;
    logic [22:0]      mant_s;
    logic             guard_s;
    logic             sticky_s;
    logic             round_up_s;
    logic [23:0]      mant_sum_s;
    logic [22:0]      mant_fin_s;
    logic [7:0]       exp_fin_s;
    logic [31:0]      rd_s;

    logic             done_r;
    logic [31:0]      rd_r;

    assign accepted = order;

    // Sign and magnitude of the incoming operand. Negating the most-negative
    // value wraps back to 2^(WIDTH-1), which is the right unsigned magnitude.
    always_comb begin
        sign_s = rs1[WIDTH-1] & ~is_unsigned;
        if (sign_s) begin
            mag_s = ~rs1 + WIDTH'(1);
        end else begin
            mag_s = rs1;
        end
    end

    generate
        if (LATENCY >= 3) begin : g_s1_reg
            // S1 register: sign, magnitude and rounding mode
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    s1_valid <= 1'b0;
                    s1_sign  <= 1'b0;
                    s1_mag   <= '0;
                    s1_rm    <= 1'b0;
                end else begin
                    s1_valid <= order;
                    if (order) begin
                        s1_sign <= sign_s;
                        s1_mag  <= mag_s;
                        s1_rm   <= rm;
                    end
                end
            end
        end else begin : g_s1_wire
            assign s1_valid = order;
            assign s1_sign  = sign_s;
            assign s1_mag   = mag_s;
            assign s1_rm    = rm;
        end
    endgenerate

    // Normalise: shift the leading one up to bit 31 of a 32-bit field so the
    // mantissa, guard and sticky positions are fixed for every WIDTH. Narrow
    // operands are zero-filled below their last bit.
    always_comb begin
        lzc_s     = count_lz(s1_mag);
        shifted_s = s1_mag << lzc_s;
        norm_s    = 32'(shifted_s) << ALIGN;
    end

    generate
        if (LATENCY >= 2) begin : g_s2_reg
            // S2 register: leading-zero count and normalised magnitude
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    s2_valid <= 1'b0;
                    s2_sign  <= 1'b0;
                    s2_rm    <= 1'b0;
                    s2_lzc   <= 6'd0;
                    s2_norm  <= 32'h0000_0000;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_sign <= s1_sign;
                        s2_rm   <= s1_rm;
                        s2_lzc  <= lzc_s;
                        s2_norm <= norm_s;
                    end
                end
            end
        end else begin : g_s2_wire
            assign s2_valid = s1_valid;
            assign s2_sign  = s1_sign;
            assign s2_rm    = s1_rm;
            assign s2_lzc   = lzc_s;
            assign s2_norm  = norm_s;
        end
    endgenerate

    // Round and pack. Bit 31 of the normalised field is clear only for a zero
    // operand, which therefore doubles as the zero detect (always +0).
    always_comb begin
        exp_base_s = EXP_TOP - {2'b00, s2_lzc};
        mant_s     = s2_norm[30:8];
        guard_s    = s2_norm[7];
        sticky_s   = |s2_norm[6:0];
        round_up_s = ~s2_rm & guard_s & (sticky_s | mant_s[0]);
        mant_sum_s = {1'b0, mant_s} + {23'd0, round_up_s};
        if (mant_sum_s[23]) begin
            mant_fin_s = 23'd0;
            exp_fin_s  = exp_base_s + 8'd1;
        end else begin
            mant_fin_s = mant_sum_s[22:0];
            exp_fin_s  = exp_base_s;
        end
        if (s2_norm[31]) begin
            rd_s = {s2_sign, exp_fin_s, mant_fin_s};
        end else begin
            rd_s = 32'h0000_0000;
        end
    end

    // S3 register: done pulse and result, result held between operations
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_r <= 1'b0;
            rd_r   <= 32'h0000_0000;
        end else begin
            done_r <= s2_valid;
            if (s2_valid) begin
                rd_r <= rd_s;
            end
        end
    end

    assign done = done_r;
    assign rd   = rd_r;

`ifdef ITOF_PIPE_INEXACT_EN
    logic nx_s;
    logic nx_r;

    assign nx_s = guard_s | sticky_s;

    // S3 inexact flag, captured alongside rd
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            nx_r <= 1'b0;
        end else begin
            if (s2_valid) begin
                nx_r <= nx_s;
            end
        end
    end

    assign nx = nx_r;
`endif

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe: a 32-bit/latency-3 instance and a
// 16-bit/latency-1 instance, each with a scoreboard queue filled at issue
// time and drained by a monitor when done pulses.
module tb_itof_pipe;

    logic        clk;
    logic        rstn;

    logic        order;
    logic        accepted;
    logic        done;
    logic [31:0] rs1;
    logic        is_unsigned;
    logic        rm;
    logic [31:0] rd;

    logic        order16;
    logic        acc16;
    logic        done16;
    logic [15:0] rs1_16;
    logic        uns16;
    logic        rm16;
    logic [31:0] rd16;

`ifdef ITOF_PIPE_INEXACT_EN
    logic        nx;
    logic        nx16;
`endif

    typedef struct {
        logic [31:0] rd;
        logic        nx;
        int          cyc;
    } exp_t;

    exp_t        q32[$];
    exp_t        q16[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] last_rd  = 32'h0;

    itof_pipe #(.WIDTH(32), .LATENCY(3)) u_dut (
        .clk(clk), .rstn(rstn), .order(order), .accepted(accepted),
        .done(done), .rs1(rs1), .is_unsigned(is_unsigned), .rm(rm), .rd(rd)
`ifdef ITOF_PIPE_INEXACT_EN
        , .nx(nx)
`endif
    );

    itof_pipe #(.WIDTH(16), .LATENCY(1)) u_dut16 (
        .clk(clk), .rstn(rstn), .order(order16), .accepted(acc16),
        .done(done16), .rs1(rs1_16), .is_unsigned(uns16), .rm(rm16), .rd(rd16)
`ifdef ITOF_PIPE_INEXACT_EN
        , .nx(nx16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Scoreboard monitor for the 32-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (q32.size() == 0) begin
                check("unexpected_done32", {31'd0, done}, 32'd0);
            end else begin
                e = q32.pop_front();
                check("rd32", rd, e.rd);
                check("latency32", 32'(cyc), 32'(e.cyc));
`ifdef ITOF_PIPE_INEXACT_EN
                check("nx32", {31'd0, nx}, {31'd0, e.nx});
`endif
                last_rd = e.rd;
            end
        end
    end

    // Scoreboard monitor for the 16-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (done16 === 1'b1) begin
            if (q16.size() == 0) begin
                check("unexpected_done16", {31'd0, done16}, 32'd0);
            end else begin
                e = q16.pop_front();
                check("rd16", rd16, e.rd);
                check("latency16", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic send32(input logic [31:0] v, input logic u, input logic r,
                          input logic [31:0] e_rd, input logic e_nx);
        exp_t e;
        @(negedge clk);
        order = 1'b1; rs1 = v; is_unsigned = u; rm = r;
        e.rd = e_rd; e.nx = e_nx; e.cyc = cyc + 3;
        q32.push_back(e);
        #1 check("accepted32", {31'd0, accepted}, 32'd1);
    endtask

    task automatic send16(input logic [15:0] v, input logic u, input logic r,
                          input logic [31:0] e_rd);
        exp_t e;
        @(negedge clk);
        order16 = 1'b1; rs1_16 = v; uns16 = u; rm16 = r;
        e.rd = e_rd; e.nx = 1'b0; e.cyc = cyc + 1;
        q16.push_back(e);
        #1 check("accepted16", {31'd0, acc16}, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            order = 1'b0; order16 = 1'b0;
            rs1 = 32'hDEAD_BEEF; rs1_16 = 16'hBEEF;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (q32.size() != 0 || q16.size() != 0); i++) begin
            @(negedge clk);
            order = 1'b0; order16 = 1'b0;
        end
        check("drain32", 32'(q32.size()), 32'd0);
        check("drain16", 32'(q16.size()), 32'd0);
    endtask

    initial begin
        rstn = 1'b0; order = 1'b0; rs1 = 32'h0; is_unsigned = 1'b0; rm = 1'b0;
        order16 = 1'b0; rs1_16 = 16'h0; uns16 = 1'b0; rm16 = 1'b0;
        #1;
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_rd", rd, 32'h0);
        check("reset_rd16", rd16, 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        idle(2);
        check("idle_accepted", {31'd0, accepted}, 32'd0);

        // Basic conversions, round-to-nearest-even, signed
        send32(32'd1, 1'b0, 1'b0, 32'h3F80_0000, 1'b0);
        idle(5);
        check("hold_rd", rd, last_rd);
        check("hold_done", {31'd0, done}, 32'd0);
        send32(32'd0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        send32(32'hFFFF_FFFF, 1'b0, 1'b0, 32'hBF80_0000, 1'b0);
        send32(32'd0, 1'b1, 1'b0, 32'h0000_0000, 1'b0);

        // Rounding
        send32(32'h7FFF_FFFF, 1'b0, 1'b0, 32'h4F00_0000, 1'b1);
        send32(32'h7FFF_FFFF, 1'b0, 1'b1, 32'h4EFF_FFFF, 1'b1);
        send32(32'd16777217, 1'b0, 1'b0, 32'h4B80_0000, 1'b1);
        send32(32'd16777219, 1'b0, 1'b0, 32'h4B80_0002, 1'b1);
        send32(32'd2, 1'b0, 1'b0, 32'h4000_0000, 1'b0);

        // Extremes and unsigned
        send32(32'h8000_0000, 1'b0, 1'b0, 32'hCF00_0000, 1'b0);
        send32(32'h8000_0000, 1'b1, 1'b0, 32'h4F00_0000, 1'b0);
        send32(32'hFFFF_FFFF, 1'b1, 1'b0, 32'h4F80_0000, 1'b1);
        send32(32'hFFFF_FFFF, 1'b1, 1'b1, 32'h4F7F_FFFF, 1'b1);
        idle(1);
        drain();

        // Throughput: five back-to-back orders
        send32(32'd1, 1'b0, 1'b0, 32'h3F80_0000, 1'b0);
        send32(32'd2, 1'b0, 1'b0, 32'h4000_0000, 1'b0);
        send32(32'd3, 1'b0, 1'b0, 32'h4040_0000, 1'b0);
        send32(32'd4, 1'b0, 1'b0, 32'h4080_0000, 1'b0);
        send32(32'd5, 1'b0, 1'b0, 32'h40A0_0000, 1'b0);
        idle(1);
        drain();

        // Reset with two operations in flight: both are discarded
        send32(32'd10, 1'b0, 1'b0, 32'h4120_0000, 1'b0);
        send32(32'd20, 1'b0, 1'b0, 32'h41A0_0000, 1'b0);
        @(negedge clk);
        order = 1'b0;
        rstn  = 1'b0;
        q32.delete();
        #1;
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_rd", rd, 32'h0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("postreset_done", {31'd0, done}, 32'd0);
        end
        check("postreset_rd", rd, 32'h0);
        send32(32'd7, 1'b0, 1'b0, 32'h40E0_0000, 1'b0);
        idle(1);
        drain();

        // 16-bit, latency-1 instance
        send16(16'h8000, 1'b0, 1'b0, 32'hC700_0000);
        send16(16'h7FFF, 1'b0, 1'b0, 32'h46FF_FE00);
        send16(16'hFFFF, 1'b0, 1'b0, 32'hBF80_0000);
        send16(16'h8000, 1'b1, 1'b0, 32'h4700_0000);
        idle(1);
        drain();
        idle(2);
        check("hold_rd16", rd16, 32'h4700_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
